// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for the valid/ready CPU memory bus.
// Optional forced completion of stalled transactions via `ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state, state_nxt;
    logic   owner, owner_nxt;
    logic   last_owner, last_owner_nxt;
    logic   expire_c;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // Expiry only when the downstream has not answered in this same cycle.
    assign expire_c = (state == BUSY) && !s_ready &&
                      (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_nxt = cnt;
        if (state == IDLE)
            cnt_nxt = '0;
        else if (!s_ready)
            cnt_nxt = cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt <= '0;
        else
            cnt <= cnt_nxt;
    end
`else
    assign expire_c = 1'b0;
    wire [CNT_W-1:0] unused_timeout_cfg = CNT_W'(TIMEOUT_CYCLES);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    // Next-state: arbitration in IDLE, completion in BUSY
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        case (state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_nxt = BUSY;
                    if (m0_valid && m1_valid)
                        owner_nxt = ~last_owner;
                    else
                        owner_nxt = m1_valid;
                end
            end
            BUSY: begin
                if (s_ready || expire_c) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = owner;
                end
            end
        endcase
    end

    // Outputs: downstream mux and completion routing to the owner only
    always_comb begin
        s_valid     = 1'b0;
        s_instr     = 1'b0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        grant       = 2'b00;
        m0_ready    = 1'b0;
        m0_rdata    = '0;
        m1_ready    = 1'b0;
        m1_rdata    = '0;
        timeout_err = 1'b0;
        if (state == BUSY) begin
            s_valid = 1'b1;
            if (!owner) begin
                grant   = 2'b01;
                s_instr = m0_instr;
                s_addr  = m0_addr;
                s_wdata = m0_wdata;
                s_wstrb = m0_wstrb;
            end else begin
                grant   = 2'b10;
                s_addr  = m1_addr;
                s_wdata = m1_wdata;
                s_wstrb = m1_wstrb;
            end
            // An aborting reset suppresses the completion pulse.
            if (reset_n && (s_ready || expire_c)) begin
                if (!owner) begin
                    m0_ready = 1'b1;
                    m0_rdata = expire_c ? 32'h0 : s_rdata;
                end else begin
                    m1_ready = 1'b1;
                    m1_rdata = expire_c ? 32'h0 : s_rdata;
                end
            end
            timeout_err = reset_n && expire_c;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, a randomized
// transaction loop against a round-robin reference, and multi-cycle corner cases.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_valid, m0_instr, m0_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_wstrb;
    logic        m1_valid, m1_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_wstrb;
    logic        s_valid, s_instr, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    // Reference state: who was served last, and each requester's held request.
    int          last;
    logic        r_instr0;
    logic [31:0] r_a  [2];
    logic [31:0] r_wd [2];
    logic [3:0]  r_ws [2];

    mem_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready),
        .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_ready(s_ready),
        .s_rdata(s_rdata), .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v0, v1;
        logic        instr0;
        logic [31:0] a0, a1, wd0, wd1;
        logic [3:0]  ws0, ws1;
        int          dly;
        logic [31:0] rd;
        int          exp_w;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input bit v0, input bit v1, input int lst);
        if (v0 && v1) return 1 - lst;
        return v1 ? 1 : 0;
    endfunction

    task automatic drive_reqs(input bit v0, input bit v1);
        m0_valid = v0;       m1_valid = v1;
        m0_instr = r_instr0;
        m0_addr  = r_a[0];   m1_addr  = r_a[1];
        m0_wdata = r_wd[0];  m1_wdata = r_wd[1];
        m0_wstrb = r_ws[0];  m1_wstrb = r_ws[1];
    endtask

    // One full transaction from IDLE: grant, dly wait cycles, completion, back to IDLE.
    task automatic do_txn(input bit v0, input bit v1, input int w, input int dly,
                          input logic [31:0] rd);
        drive_reqs(v0, v1);
        s_ready = 1'b0;
        #1;
        chk("idle_s_valid", 32'(s_valid), 0);
        chk("idle_grant", 32'(grant), 0);
        tick();
        chk("busy_s_valid", 32'(s_valid), 1);
        chk("busy_grant", 32'(grant), (w == 1) ? 2 : 1);
        chk("s_addr", s_addr, r_a[w]);
        chk("s_wdata", s_wdata, r_wd[w]);
        chk("s_wstrb", 32'(s_wstrb), 32'(r_ws[w]));
        chk("s_instr", 32'(s_instr), (w == 0) ? 32'(r_instr0) : 0);
        for (int k = 0; k < dly; k++) begin
            chk("wait_m0_ready", 32'(m0_ready), 0);
            chk("wait_m1_ready", 32'(m1_ready), 0);
            tick();
        end
        s_ready = 1'b1;
        s_rdata = rd;
        #1;
        chk("owner_ready", 32'((w == 0) ? m0_ready : m1_ready), 1);
        chk("owner_rdata", (w == 0) ? m0_rdata : m1_rdata, rd);
        chk("other_ready", 32'((w == 0) ? m1_ready : m0_ready), 0);
        chk("other_rdata", (w == 0) ? m1_rdata : m0_rdata, 0);
        chk("no_timeout_err", 32'(timeout_err), 0);
        tick();
        s_ready = 1'b0;
        s_rdata = '0;
        if (w == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
        #1;
        chk("post_s_valid", 32'(s_valid), 0);
        chk("post_grant", 32'(grant), 0);
        last = w;
    endtask

    initial begin
        bit pv [2];
        reset_n = 1'b0;
        s_ready = 1'b0; s_rdata = '0;
        r_instr0 = 1'b0;
        for (int i = 0; i < 2; i++) begin r_a[i] = '0; r_wd[i] = '0; r_ws[i] = '0; end
        drive_reqs(1'b0, 1'b0);
        last = 1;

        // Single m0 read, m1 write, then six-way strict alternation under contention.
        vecs[0] = '{1, 0, 1, 32'h4000_0010, 0, 0, 0, 4'h0, 4'h0, 1, 32'hDEAD_BEEF, 0};
        vecs[1] = '{0, 1, 0, 0, 32'hC000_0000, 0, 32'h1234_5678, 4'h0, 4'hF, 0, 32'h0, 1};
        vecs[2] = '{1, 1, 0, 32'h0000_0100, 32'h2000_0004, 32'h11, 32'h22, 4'h1, 4'h3, 0, 32'hA5A5_0001, 0};
        vecs[3] = '{1, 1, 1, 32'h0000_0104, 32'h2000_0008, 32'h33, 32'h44, 4'h0, 4'hC, 2, 32'hA5A5_0002, 1};
        vecs[4] = '{1, 1, 1, 32'h0000_0108, 32'h2000_000C, 32'h55, 32'h66, 4'h0, 4'h0, 1, 32'hA5A5_0003, 0};
        vecs[5] = '{1, 1, 0, 32'h0000_010C, 32'h2000_0010, 32'h77, 32'h88, 4'hF, 4'h2, 0, 32'hA5A5_0004, 1};
        vecs[6] = '{1, 1, 1, 32'h0000_0110, 32'h2000_0014, 32'h99, 32'hAA, 4'h0, 4'h8, 3, 32'hA5A5_0005, 0};
        vecs[7] = '{1, 1, 0, 32'h0000_0114, 32'h2000_0018, 32'hBB, 32'hCC, 4'h6, 4'h0, 0, 32'hA5A5_0006, 1};

        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("rst_s_valid", 32'(s_valid), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_m0_ready", 32'(m0_ready), 0);
        chk("rst_m1_ready", 32'(m1_ready), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);

        for (int i = 0; i < 8; i++) begin
            r_instr0 = vecs[i].instr0;
            r_a[0] = vecs[i].a0;   r_a[1] = vecs[i].a1;
            r_wd[0] = vecs[i].wd0; r_wd[1] = vecs[i].wd1;
            r_ws[0] = vecs[i].ws0; r_ws[1] = vecs[i].ws1;
            do_txn(vecs[i].v0, vecs[i].v1, vecs[i].exp_w, vecs[i].dly, vecs[i].rd);
        end

        // s_ready while IDLE must be ignored.
        drive_reqs(1'b0, 1'b0);
        s_ready = 1'b1; s_rdata = 32'hFFFF_FFFF;
        #1;
        chk("idle_sready_m0", 32'(m0_ready), 0);
        chk("idle_sready_m1", 32'(m1_ready), 0);
        tick();
        s_ready = 1'b0; s_rdata = '0;
        #1;
        chk("idle_sready_state", 32'(s_valid), 0);

        // Randomized traffic; a losing requester keeps its request held.
        pv[0] = 1'b0; pv[1] = 1'b0;
        for (int n = 0; n < 40; n++) begin
            int w;
            for (int i = 0; i < 2; i++) begin
                if (!pv[i]) begin
                    pv[i]   = 1'($urandom_range(0, 1));
                    r_a[i]  = $urandom;
                    r_wd[i] = $urandom;
                    r_ws[i] = 4'($urandom);
                    if (i == 0) r_instr0 = 1'($urandom);
                end
            end
            if (!pv[0] && !pv[1]) pv[$urandom_range(0, 1)] = 1'b1;
            w = pick(pv[0], pv[1], last);
            do_txn(pv[0], pv[1], w, $urandom_range(0, 3), $urandom);
            pv[w] = 1'b0;
        end
        drive_reqs(1'b0, 1'b0);
        tick();

        // Reset in the middle of an m1 transaction.
        r_a[1] = 32'h3000_0000; r_wd[1] = 32'h5; r_ws[1] = 4'h1;
        drive_reqs(1'b0, 1'b1);
        tick();
        chk("abort_grant_m1", 32'(grant), 2);
        reset_n = 1'b0;
        s_ready = 1'b1; s_rdata = 32'h1111_2222;
        #1;
        chk("abort_no_ready", 32'(m1_ready), 0);
        tick();
        reset_n = 1'b1;
        s_ready = 1'b0; s_rdata = '0;
        drive_reqs(1'b0, 1'b0);
        #1;
        chk("abort_grant", 32'(grant), 0);
        chk("abort_s_valid", 32'(s_valid), 0);
        chk("abort_m1_ready", 32'(m1_ready), 0);
        last = 1;
        r_a[0] = 32'h0000_0040; r_wd[0] = 32'h0; r_ws[0] = 4'h0; r_instr0 = 1'b1;
        do_txn(1'b1, 1'b1, pick(1'b1, 1'b1, last), 0, 32'h0BAD_F00D);

        // Stalled downstream: forced completion on the 8th BUSY cycle, or none at all.
        r_a[0] = 32'h0000_0200; r_instr0 = 1'b0;
        drive_reqs(1'b1, 1'b0);
        s_rdata = 32'hCAFE_CAFE;
        tick();
        for (int k = 1; k < 8; k++) begin
            chk("stall_m0_ready", 32'(m0_ready), 0);
            chk("stall_timeout_err", 32'(timeout_err), 0);
            chk("stall_s_valid", 32'(s_valid), 1);
            tick();
        end
`ifdef ARB_TIMEOUT_EN
        chk("to_m0_ready", 32'(m0_ready), 1);
        chk("to_err", 32'(timeout_err), 1);
        chk("to_m0_rdata", m0_rdata, 0);
        chk("to_m1_ready", 32'(m1_ready), 0);
        tick();
        drive_reqs(1'b0, 1'b0);
        #1;
        chk("to_post_idle", 32'(s_valid), 0);
        chk("to_post_grant", 32'(grant), 0);
        last = 0;
        // Downstream answers exactly on the expiry cycle: normal completion.
        drive_reqs(1'b1, 1'b0);
        tick();
        repeat (7) tick();
        s_ready = 1'b1;
        #1;
        chk("edge_m0_ready", 32'(m0_ready), 1);
        chk("edge_no_err", 32'(timeout_err), 0);
        chk("edge_m0_rdata", m0_rdata, 32'hCAFE_CAFE);
        tick();
        s_ready = 1'b0;
        drive_reqs(1'b0, 1'b0);
        #1;
        chk("edge_post_idle", 32'(s_valid), 0);
`else
        for (int k = 8; k <= 20; k++) begin
            chk("hold_s_valid", 32'(s_valid), 1);
            chk("hold_m0_ready", 32'(m0_ready), 0);
            chk("hold_timeout_err", 32'(timeout_err), 0);
            tick();
        end
        s_ready = 1'b1;
        #1;
        chk("late_m0_ready", 32'(m0_ready), 1);
        chk("late_m0_rdata", m0_rdata, 32'hCAFE_CAFE);
        tick();
        s_ready = 1'b0;
        drive_reqs(1'b0, 1'b0);
        #1;
        chk("late_post_idle", 32'(s_valid), 0);
`endif
        s_rdata = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
